// File: rtl/reg_add_hold.sv
// Adder hold register (ADD): latches the ALU result and drives it onto the ADL bus
// and onto the SB bus through independently enabled output registers.
module reg_add_hold (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ALU_LOAD,
  input  logic       ADL_BUS_ENABLE,
  input  logic       SB_L_BUS_ENABLE,
  input  logic       SB_H_BUS_ENABLE,
  input  logic [7:0] ALU_DATA,
  output logic [7:0] ADL_BUS,
  output logic [7:0] SB_BUS
);

  logic [7:0] hold_q;
  logic [7:0] adl_q;
  logic [6:0] sb_lo_q;
  logic       sb_hi_q;

  // Hold register: only ALU_LOAD moves it, so ALU_DATA glitches are invisible.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_q <= 8'h00;
    end else if (ALU_LOAD) begin
      hold_q <= ALU_DATA;
    end
  end

  // All output registers read hold_q, i.e. the value from before this edge,
  // so a same-edge load only becomes visible after a later enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      adl_q <= 8'h00;
    end else if (ADL_BUS_ENABLE) begin
      adl_q <= hold_q;
    end
  end

  // SB is split so bit 7 can be written separately from bits 6:0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sb_lo_q <= 7'h00;
    end else if (SB_L_BUS_ENABLE) begin
      sb_lo_q <= hold_q[6:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sb_hi_q <= 1'b0;
    end else if (SB_H_BUS_ENABLE) begin
      sb_hi_q <= hold_q[7];
    end
  end

  assign ADL_BUS = adl_q;
  assign SB_BUS  = {sb_hi_q, sb_lo_q};

endmodule

// File: tb/tb_reg_add_hold.sv
// Directed plus randomized bench for reg_add_hold, checked against a byte-level
// model of the hold/ADL/SB registers.
module tb_reg_add_hold;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n = 1'b1;
  logic       alu_load = 1'b0;
  logic       adl_en = 1'b0;
  logic       sbl_en = 1'b0;
  logic       sbh_en = 1'b0;
  logic [7:0] alu_data = 8'h00;
  logic [7:0] adl_bus;
  logic [7:0] sb_bus;

  int checks = 0;
  int errors = 0;

  // Reference state: what the hold register and both buses should contain.
  logic [7:0]  m_hold = 8'h00;
  logic [7:0]  m_adl  = 8'h00;
  logic [7:0]  m_sb   = 8'h00;
  logic [15:0] exp_q[$];

  reg_add_hold dut (
    .CLK             (clk),
    .RST_N           (rst_n),
    .ALU_LOAD        (alu_load),
    .ADL_BUS_ENABLE  (adl_en),
    .SB_L_BUS_ENABLE (sbl_en),
    .SB_H_BUS_ENABLE (sbh_en),
    .ALU_DATA        (alu_data),
    .ADL_BUS         (adl_bus),
    .SB_BUS          (sb_bus)
  );

  // Clock / reset block: clock can be held stopped to show reset is asynchronous.
  initial forever #5 clk = clk_run ? ~clk : 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: model result is queued, then popped and compared with both buses.
  task automatic compare_buses(input string tag);
    logic [15:0] e;
    exp_q.push_back({m_adl, m_sb});
    e = exp_q.pop_front();
    check({tag, "_adl"}, adl_bus, e[15:8]);
    check({tag, "_sb"},  sb_bus,  e[7:0]);
  endtask

  // Model update for one rising edge: outputs copy the pre-edge hold byte
  // under a per-bit write mask, then the hold byte takes the new ALU value.
  task automatic model_edge(input logic ld, ae, sl, sh, input logic [7:0] d);
    logic [7:0] mask;
    mask = (sl ? 8'h7f : 8'h00) | (sh ? 8'h80 : 8'h00);
    if (ae) m_adl = m_hold;
    m_sb = (m_sb & ~mask) | (m_hold & mask);
    if (ld) m_hold = d;
  endtask

  // Driver: apply controls on the falling edge, clock once, sample 1 ns later.
  task automatic step(input string tag, input logic ld, ae, sl, sh, input logic [7:0] d);
    @(negedge clk);
    alu_load = ld; adl_en = ae; sbl_en = sl; sbh_en = sh; alu_data = d;
    @(posedge clk);
    model_edge(ld, ae, sl, sh, d);
    #1;
    compare_buses(tag);
    alu_load = 1'b0; adl_en = 1'b0; sbl_en = 1'b0; sbh_en = 1'b0;
  endtask

  // Reset dropped between edges; held across an edge with every control high.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    m_hold = 8'h00; m_adl = 8'h00; m_sb = 8'h00;
    #1;
    compare_buses({tag, "_imm"});
    alu_load = 1'b1; adl_en = 1'b1; sbl_en = 1'b1; sbh_en = 1'b1;
    alu_data = 8'($urandom_range(1, 255));
    @(posedge clk);
    #1;
    compare_buses({tag, "_held"});
    @(negedge clk);
    alu_load = 1'b0; adl_en = 1'b0; sbl_en = 1'b0; sbh_en = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with the clock stopped.
    #3 rst_n = 1'b0;
    #4;
    check("rst_noclk_adl", adl_bus, 8'h00);
    check("rst_noclk_sb",  sb_bus,  8'h00);
    #3 rst_n = 1'b1;
    clk_run = 1'b1;
    step("rel_adl", 0, 1, 0, 0, 8'h00);
    check("rel_adl_const", adl_bus, 8'h00);

    // Load isolation.
    step("noload_adl", 0, 1, 0, 0, 8'hff);
    check("noload_adl_const", adl_bus, 8'h00);
    step("load_ff", 1, 0, 0, 0, 8'hff);
    step("adl_ff", 0, 1, 0, 0, 8'hff);
    check("adl_ff_const", adl_bus, 8'hff);
    check("sb_still_00", sb_bus, 8'h00);

    // Split SB.
    step("sbl_7f", 0, 0, 1, 0, 8'h00);
    check("sbl_7f_const", sb_bus, 8'h7f);
    step("load_00", 1, 0, 0, 0, 8'h00);
    step("sbh_0", 0, 0, 0, 1, 8'h00);
    check("sbh_0_const_sb", sb_bus, 8'h7f);
    check("sbh_0_const_adl", adl_bus, 8'hff);
    step("load_80", 1, 0, 0, 0, 8'h80);
    step("sbh_1", 0, 0, 0, 1, 8'h80);
    check("sbh_1_const", sb_bus, 8'hff);

    // Simultaneous load and enables see the old hold value.
    step("load_12", 1, 0, 0, 0, 8'h12);
    step("all_34", 1, 1, 1, 1, 8'h34);
    check("all_34_adl_const", adl_bus, 8'h12);
    check("all_34_sb_const",  sb_bus,  8'h12);
    step("adl_34", 0, 1, 0, 0, 8'h00);
    check("adl_34_const", adl_bus, 8'h34);

    // Hold behaviour with ALU_DATA churning.
    step("load_a5", 1, 0, 0, 0, 8'ha5);
    step("drive_a5", 0, 1, 1, 1, 8'h00);
    for (int i = 0; i < 20; i++) step("idle", 0, 0, 0, 0, 8'($urandom));
    check("idle_adl_const", adl_bus, 8'ha5);
    check("idle_sb_const",  sb_bus,  8'ha5);

    // Asynchronous reset mid-operation.
    step("load_5a", 1, 0, 0, 0, 8'h5a);
    step("drive_5a", 0, 1, 1, 1, 8'h00);
    check("drive_5a_const", sb_bus, 8'h5a);
    async_reset("arst");
    step("arst_adl", 0, 1, 0, 0, 8'h00);
    check("arst_adl_const", adl_bus, 8'h00);

    // Randomized traffic, including held controls and occasional resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset("rnd_rst");
      else step("rnd", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
